block_check_arbiter: RTL and testbench

//  Shares one begin/end block-checker engine among NREQ character-stream requesters.

---
 rtl/block_check_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_block_check_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_check_arbiter.sv
// Round-robin arbiter that lends one begin/end checker engine to NREQ char streams,
// buffering whole words so the engine only ever sees filler spaces between words.

module block_check_arbiter_checker #(
  parameter int NREQ = 2
) (
  input logic            clk,
  input logic            reset,
  input logic [NREQ-1:0] gnt,
  input logic            done,
  input logic            in_ready
);

  gntOneHot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
  doneHasGnt: assert property (@(posedge clk) disable iff (!reset) done |-> (gnt != {NREQ{1'b0}}));
  readyHasGnt: assert property (@(posedge clk) disable iff (!reset) in_ready |-> (gnt != {NREQ{1'b0}}));

endmodule

module block_check_arbiter #(
  parameter int NREQ = 2,
  parameter int TOKW = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  input  logic [NREQ-1:0]          in_valid,
  input  logic [NREQ*8-1:0]        in_data,
  input  logic [NREQ-1:0]          in_last,
  output logic                     in_ready,
  output logic [7:0]               chk_in,
  output logic                     chk_reset,
  input  logic                     chk_result,
  output logic                     done,
  output logic                     done_result,
  output logic [$clog2(NREQ)-1:0]  done_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int LENW = $clog2(TOKW + 1);
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    COLLECT = 3'd2,
    BURST   = 3'd3,
    FLUSH   = 3'd4,
    WAIT    = 3'd5,
    DONE    = 3'd6
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [IDW-1:0]   ptr;
  logic [7:0]       wordBuf [TOKW];
  logic [LENW-1:0]  len;
  logic [LENW-1:0]  idx;
  logic             lastPend;

  logic [IDW-1:0]   selId;
  logic             selValid;
  int               cand;
  logic             curValid;
  logic [7:0]       curData;
  logic             curLast;
  logic             accept;
  logic             isSpace;
  logic             canAppend;
  logic [LENW-1:0]  lenAfter;

  // Round-robin pick: first requester at or after ptr, wrapping around.
  always_comb begin
    selId = {IDW{1'b0}};
    selValid = 1'b0;
    cand = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      selId = (!selValid && req[cand]) ? IDW'(cand) : selId;
      selValid = selValid | req[cand];
    end
  end

  // Granted channel decode and word-buffer append decision.
  always_comb begin
    curValid = in_valid[done_id];
    curData = in_data[{done_id, 3'b000} +: 8];
    curLast = in_last[done_id];
    accept = (state == COLLECT) && curValid;
    isSpace = (curData == SPACE);
    canAppend = !isSpace && (len < LENW'(TOKW));
    lenAfter = canAppend ? (len + LENW'(1)) : len;
  end

  // Next-state logic; a trailing word is always burst before the session can close.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (selValid) stateNext = CLR;
        else stateNext = IDLE;
      end
      CLR: stateNext = COLLECT;
      COLLECT: begin
        if (accept && curLast) stateNext = (lenAfter != LENW'(0)) ? BURST : FLUSH;
        else if (accept && isSpace && (len != LENW'(0))) stateNext = BURST;
        else stateNext = COLLECT;
      end
      BURST: begin
        if (idx == (len - LENW'(1))) stateNext = FLUSH;
        else stateNext = BURST;
      end
      FLUSH: stateNext = lastPend ? WAIT : COLLECT;
      WAIT: stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Engine feed: buffered letters only during BURST, spaces otherwise.
  always_comb begin
    case (state)
      BURST: chk_in = wordBuf[idx];
      default: chk_in = SPACE;
    endcase
  end

  assign chk_reset = (~reset) | (state == CLR);
  assign in_ready = (state == COLLECT);
  assign done = (state == DONE);

  // Session state, grant, word buffer and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      gnt <= {NREQ{1'b0}};
      done_id <= {IDW{1'b0}};
      done_result <= 1'b0;
      ptr <= {IDW{1'b0}};
      len <= LENW'(0);
      idx <= LENW'(0);
      lastPend <= 1'b0;
      for (int i = 0; i < TOKW; i++) wordBuf[i] <= 8'h00;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (selValid) begin
            gnt <= NREQ'(1) << selId;
            done_id <= selId;
          end
        end
        CLR: begin
          lastPend <= 1'b0;
          len <= LENW'(0);
          idx <= LENW'(0);
        end
        COLLECT: begin
          if (accept) begin
            if (canAppend) wordBuf[len] <= curData;
            len <= lenAfter;
            if (curLast) lastPend <= 1'b1;
          end
        end
        BURST: idx <= idx + LENW'(1);
        FLUSH: begin
          len <= LENW'(0);
          idx <= LENW'(0);
        end
        WAIT: done_result <= chk_result;
        DONE: begin
          gnt <= {NREQ{1'b0}};
          ptr <= (done_id == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (done_id + IDW'(1));
        end
        default: ;
      endcase
    end
  end

  block_check_arbiter_checker #(.NREQ(NREQ)) checker_i (
    .clk      (clk),
    .reset    (reset),
    .gnt      (gnt),
    .done     (done),
    .in_ready (in_ready)
  );

endmodule

// File: tb/tb_block_check_arbiter.sv
// Bench for block_check_arbiter: behavioural begin/end engine, word-level reference model,
// directed sessions followed by randomized ones.

module tb_block_check_arbiter;

  localparam int NREQ = 2;
  localparam int TOKW = 6;
  localparam int IDW = 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     in_valid;
  logic [NREQ*8-1:0]   in_data;
  logic [NREQ-1:0]     in_last;
  logic                in_ready;
  logic [7:0]          chk_in;
  logic                chk_reset;
  logic                chk_result;
  logic                done;
  logic                done_result;
  logic [IDW-1:0]      done_id;

  int nAsserts = 0;
  int nFails = 0;
  int ptrModel = 0;
  int crCount = 0;

  always #5 clk = ~clk;

  block_check_arbiter #(.NREQ(NREQ), .TOKW(TOKW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .gnt         (gnt),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .chk_in      (chk_in),
    .chk_reset   (chk_reset),
    .chk_result  (chk_result),
    .done        (done),
    .done_result (done_result),
    .done_id     (done_id)
  );

  // Behavioural begin/end engine: one char per clock, words end at a space.
  byte   engWord[$];
  string engLog = "";
  int    engDepth = 0;
  bit    engErr = 1'b0;

  function automatic string wordOf(input byte q[$]);
    string w;
    w = "";
    foreach (q[i]) w = $sformatf("%s%c", w, q[i]);
    return w;
  endfunction

  assign chk_result = (engDepth == 0) && !engErr;

  always @(posedge clk) begin
    if (chk_reset) begin
      engDepth <= 0;
      engErr <= 1'b0;
      engLog <= "";
      engWord.delete();
    end else if (chk_in != 8'h20) begin
      engWord.push_back(chk_in);
    end else if (engWord.size() > 0) begin
      engLog <= {engLog, wordOf(engWord), "|"};
      if (wordOf(engWord) == "begin") engDepth <= engDepth + 1;
      else if (wordOf(engWord) == "end") begin
        if (engDepth == 0) engErr <= 1'b1;
        else engDepth <= engDepth - 1;
      end
      engWord.delete();
    end
  end

  always @(negedge clk) if (chk_reset) crCount <= crCount + 1;

  // Reference: split on spaces, truncate words to TOKW, apply begin/end rules.
  function automatic void model(input string s, output bit res, output string log, output int lastLen);
    string cur;
    int d;
    bit err;
    byte c;
    cur = ""; d = 0; err = 1'b0; log = ""; lastLen = 0;
    for (int i = 0; i <= s.len(); i++) begin
      c = (i == s.len()) ? 8'h20 : s[i];
      if (c == 8'h20) begin
        if (cur.len() > 0) begin
          log = {log, cur, "|"};
          if (cur == "begin") d++;
          else if (cur == "end") begin
            if (d == 0) err = 1'b1;
            else d--;
          end
          lastLen = cur.len();
          cur = "";
        end
      end else if (cur.len() < TOKW) begin
        cur = $sformatf("%s%c", cur, c);
      end
    end
    res = (d == 0) && !err;
  endfunction

  function automatic int pickId(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic noise(input int id);
    for (int j = 0; j < NREQ; j++) begin
      if (j != id) begin
        in_valid[j] = 1'($urandom_range(0, 1));
        in_data[8*j +: 8] = 8'($urandom);
        in_last[j] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic waitGrant(output int id);
    int n;
    logic [NREQ-1:0] expG;
    id = pickId(req, ptrModel);
    expG = NREQ'(1) << id;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 50);
    nAsserts++;
    assert (gnt === expG) else begin
      nFails++;
      $error("FAIL grant: observed=%b expected=%b", gnt, expG);
    end
    nAsserts++;
    assert (chk_reset === 1'b1) else begin
      nFails++;
      $error("FAIL clr_on_grant: observed=%b expected=1", chk_reset);
    end
  endtask

  // gaps: 0 = valid every cycle, 1 = toggling, 2 = random
  task automatic feed(input int id, input string s, input bit withLast, input int gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < s.len() && guard < 40 * s.len() + 40) begin
      guard++;
      noise(id);
      if ((gaps == 1 && guard % 2 == 0) || (gaps == 2 && $urandom_range(0, 1) == 0)) begin
        in_valid[id] = 1'b0;
      end else begin
        in_valid[id] = 1'b1;
        in_data[8*id +: 8] = s[i];
        in_last[id] = withLast && (i == s.len() - 1);
      end
      if (in_valid[id] && in_ready) i++;
      @(negedge clk);
    end
    nAsserts++;
    assert (i === s.len()) else begin
      nFails++;
      $error("FAIL feed_accept: observed=%0d expected=%0d", i, s.len());
    end
  endtask

  task automatic runSession(input string s, input logic [NREQ-1:0] mask, input bit holdReq,
                            input int gaps, output int id);
    bit expRes;
    string expLog;
    int lastLen;
    int cnt;
    int c0;
    logic [IDW-1:0] expId;
    model(s, expRes, expLog, lastLen);
    req = mask;
    c0 = crCount;
    waitGrant(id);
    expId = id[IDW-1:0];
    if (!holdReq) req = '0;
    feed(id, s, 1'b1, gaps);
    in_valid = '0;
    in_last = '0;
    cnt = 1;
    while (!done && cnt < TOKW + 20) begin
      @(negedge clk);
      cnt++;
    end
    nAsserts++;
    assert (cnt === lastLen + 3) else begin
      nFails++;
      $error("FAIL latency: observed=%0d expected=%0d", cnt, lastLen + 3);
    end
    nAsserts++;
    assert (done_id === expId) else begin
      nFails++;
      $error("FAIL done_id: observed=%0d expected=%0d", done_id, expId);
    end
    nAsserts++;
    assert (done_result === expRes) else begin
      nFails++;
      $error("FAIL done_result '%s': observed=%b expected=%b", s, done_result, expRes);
    end
    nAsserts++;
    assert (engLog == expLog) else begin
      nFails++;
      $error("FAIL engine_words: observed=%s expected=%s", engLog, expLog);
    end
    nAsserts++;
    assert ((crCount - c0) === 1) else begin
      nFails++;
      $error("FAIL clr_cycles: observed=%0d expected=1", crCount - c0);
    end
    @(negedge clk);
    nAsserts++;
    assert (done === 1'b0 && gnt === '0) else begin
      nFails++;
      $error("FAIL after_done: observed done=%b gnt=%b expected done=0 gnt=0", done, gnt);
    end
    if (!holdReq) req = '0;
    ptrModel = (id + 1) % NREQ;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int id;
    string pool [6];
    string s;
    logic [NREQ-1:0] mask;
    pool = '{"begin", "end", "beginning", "en", "endx", "a"};

    reset = 1'b0;
    req = '0;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    repeat (2) @(negedge clk);
    nAsserts++;
    assert (gnt === 2'b00 && done === 1'b0 && done_result === 1'b0 && done_id === 1'b0) else begin
      nFails++;
      $error("FAIL reset_outputs: observed gnt=%b done=%b res=%b id=%b expected all 0",
             gnt, done, done_result, done_id);
    end
    nAsserts++;
    assert (in_ready === 1'b0 && chk_reset === 1'b1 && chk_in === 8'h20) else begin
      nFails++;
      $error("FAIL reset_engine: observed ready=%b chk_reset=%b chk_in=%h expected 0/1/20",
             in_ready, chk_reset, chk_in);
    end
    reset = 1'b1;
    @(negedge clk);
    nAsserts++;
    assert (chk_reset === 1'b0) else begin
      nFails++;
      $error("FAIL idle_chk_reset: observed=%b expected=0", chk_reset);
    end

    // balanced, then sticky error, then cleared by the next session
    runSession("begin end", 2'b01, 1'b0, 0, id);
    runSession("end begin", 2'b01, 1'b0, 0, id);
    runSession("begin end", 2'b01, 1'b0, 0, id);
    // overflowing word is truncated
    runSession("beginning", 2'b01, 1'b0, 0, id);
    runSession("beginning end", 2'b01, 1'b0, 0, id);
    // gapped valid inside words
    runSession("begin end", 2'b01, 1'b0, 1, id);

    // reset during BURST of requester 1
    req = 2'b10;
    waitGrant(id);
    req = '0;
    feed(id, "begin ", 1'b0, 0);
    nAsserts++;
    assert (in_ready === 1'b0) else begin
      nFails++;
      $error("FAIL burst_ready: observed=%b expected=0", in_ready);
    end
    reset = 1'b0;
    in_valid = '0;
    in_last = '0;
    @(negedge clk);
    nAsserts++;
    assert (gnt === 2'b00 && done === 1'b0 && chk_reset === 1'b1) else begin
      nFails++;
      $error("FAIL abort: observed gnt=%b done=%b chk_reset=%b expected 00/0/1", gnt, done, chk_reset);
    end
    reset = 1'b1;
    ptrModel = 0;
    @(negedge clk);
    runSession("begin end", 2'b10, 1'b0, 0, id);
    nAsserts++;
    assert (id === 1) else begin
      nFails++;
      $error("FAIL post_reset_id: observed=%0d expected=1", id);
    end

    // both requesting: strict alternation from ptr 0
    runSession("begin end", 2'b11, 1'b1, 0, id);
    nAsserts++;
    assert (id === 0) else begin
      nFails++;
      $error("FAIL rr_first: observed=%0d expected=0", id);
    end
    runSession("end", 2'b11, 1'b1, 0, id);
    nAsserts++;
    assert (id === 1) else begin
      nFails++;
      $error("FAIL rr_second: observed=%0d expected=1", id);
    end
    runSession("begin begin end end", 2'b11, 1'b0, 2, id);
    nAsserts++;
    assert (id === 0) else begin
      nFails++;
      $error("FAIL rr_third: observed=%0d expected=0", id);
    end

    // randomized streams, masks and valid patterns
    for (int t = 0; t < 8; t++) begin
      s = "";
      for (int w = 0; w < $urandom_range(1, 4); w++) begin
        if (w > 0) s = {s, ($urandom_range(0, 1) == 1) ? "  " : " "};
        s = {s, pool[$urandom_range(0, 5)]};
      end
      mask = NREQ'($urandom_range(1, 3));
      runSession(s, mask, 1'b0, $urandom_range(0, 2), id);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
